mc_core_hs: RTL

Parametrised multicycle 32-bit MIPS-subset core with a single shared instruction/data memory port under a req/ready handshake, so memory may take any number of cycles. Successor to the fixed-timing multicycle CPU: configurable memory address width and reset vector, stall-tolerant memory access, BNE/JAL/JR support and a retire strobe. Internal register file, ALU, control FSM and datapath registers; the memory sits outside the block.

---
 rtl/mc_core_hs.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mc_core_hs.sv
// mc_core_hs: multicycle MIPS-subset core sharing one req/ready memory port for fetch and data.
// Define MC_CORE_TRAP_EN to halt in TRAP on illegal instructions; otherwise they retire as NOPs.
module mc_core_hs #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_o,
  output logic              trap
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnJr    = 6'h08;

  typedef enum logic [2:0] {
    StBoot, StFetch, StDecode, StExec, StMem, StWb
`ifdef MC_CORE_TRAP_EN
    , StTrap
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rf_a, rf_b, alu_res;
  logic        is_alu_r, is_jr, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_jal;
  logic        is_legal, is_ctrl, br_taken;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign is_alu_r = (opcode == OpRtype) && (funct == FnAdd || funct == FnSub || funct == FnSlt);
  assign is_jr    = (opcode == OpRtype) && (funct == FnJr);
  assign is_lw    = opcode == OpLw;
  assign is_sw    = opcode == OpSw;
  assign is_addi  = opcode == OpAddi;
  assign is_beq   = opcode == OpBeq;
  assign is_bne   = opcode == OpBne;
  assign is_j     = opcode == OpJ;
  assign is_jal   = opcode == OpJal;
  assign is_ctrl  = is_beq | is_bne | is_j | is_jal | is_jr;
  assign is_legal = is_alu_r | is_lw | is_sw | is_addi | is_ctrl;
  assign br_taken = (is_beq | is_bne) && ((a_q == b_q) ^ is_bne);

  assign rf_a = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rf_b = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  always_comb begin
    case (funct)
      FnSub:   alu_res = a_q - b_q;
      FnSlt:   alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
      default: alu_res = a_q + b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StBoot;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (is_legal) state_d = StExec;
`ifdef MC_CORE_TRAP_EN
        else          state_d = StTrap;
`else
        else          state_d = StFetch;
`endif
      end
      StExec: begin
        if (is_lw || is_sw) state_d = StMem;
        else if (is_ctrl)   state_d = StFetch;
        else                state_d = StWb;
      end
      StMem:   if (mem_ready) state_d = is_lw ? StWb : StFetch;
      StWb:    state_d = StFetch;
`ifdef MC_CORE_TRAP_EN
      StTrap:  state_d = StTrap;
`endif
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == StFetch) || (state_q == StMem);
    mem_we    = (state_q == StMem) && is_sw;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (state_q == StFetch) mem_addr = pc_q[ADDR_W+1:2];
    if (state_q == StMem) begin
      mem_addr  = alu_q[ADDR_W+1:2];
      mem_wdata = b_q;
    end
    retire = (state_q == StWb) ||
             (state_q == StExec && is_ctrl) ||
             (state_q == StMem && is_sw && mem_ready);
`ifndef MC_CORE_TRAP_EN
    // Unrecognised instructions complete as NOPs straight out of DECODE.
    if (state_q == StDecode && !is_legal) retire = 1'b1;
`endif
  end

`ifdef MC_CORE_TRAP_EN
  assign trap = state_q == StTrap;
`else
  assign trap = 1'b0;
`endif
  assign pc_o = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= 32'h0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      alu_q <= 32'h0;
      mdr_q <= 32'h0;
    end else begin
      case (state_q)
        StFetch: begin
          if (mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        StDecode: begin
          a_q   <= rf_a;
          b_q   <= rf_b;
          alu_q <= pc_q + {imm_sext[29:0], 2'b00};
        end
        StExec: begin
          if (is_alu_r)                       alu_q <= alu_res;
          else if (is_lw || is_sw || is_addi) alu_q <= a_q + imm_sext;
          if (br_taken)                       pc_q  <= alu_q;
          else if (is_j || is_jal)            pc_q  <= {pc_q[31:28], ir_q[25:0], 2'b00};
          else if (is_jr)                     pc_q  <= a_q;
        end
        StMem: if (mem_ready && is_lw) mdr_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // JAL links in EXEC; every other register write happens in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    if (state_q == StExec && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc_q;
    end else if (state_q == StWb) begin
      rf_we    = 1'b1;
      rf_waddr = is_alu_r ? rd : rt;
      rf_wdata = is_lw ? mdr_q : alu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
  end

endmodule
